wb_stage: RTL

//  Write-back end of the register-file write port: MEM/WB pipeline register plus result select.

---
 rtl/arm_pkg.sv | 13 +
 rtl/wb_pipe_reg.sv | 49 ++++
 rtl/wb_stage.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared types and constants for the pipeline back end.
package arm_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_t;

    localparam int             REG_IDX_W = 4;
    localparam int             DATA_W    = 32;
    localparam logic [3:0]     REG_PC    = 4'd15;

endpackage

// File: rtl/wb_pipe_reg.sv
// MEM/WB pipeline register: captures one op per cycle, or holds its contents
// with valid dropped so a held op is never written twice.
module wb_pipe_reg
    import arm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_freeze,
    input  logic                 i_flush,
    input  logic                 i_valid,
    input  logic                 i_wb_en,
    input  logic [REG_IDX_W-1:0] i_dest,
    input  logic [DATA_W-1:0]    i_value,
    output logic                 o_valid,
    output logic                 o_wb_en,
    output logic [REG_IDX_W-1:0] o_dest,
    output logic [DATA_W-1:0]    o_value
);

    logic                 r_valid;
    logic                 r_wb_en;
    logic [REG_IDX_W-1:0] r_dest;
    logic [DATA_W-1:0]    r_value;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_wb_en <= 1'b0;
            r_dest  <= '0;
            r_value <= '0;
        end else if (i_flush || i_freeze) begin
            // Payload is kept; only the write qualifier is dropped.
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_valid;
            r_wb_en <= i_wb_en;
            r_dest  <= i_dest;
            r_value <= i_value;
        end
    end

    assign o_valid = r_valid;
    assign o_wb_en = r_wb_en;
    assign o_dest  = r_dest;
    assign o_value = r_value;

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB register, load wait FSM with timeout, result select.
// Optional WB_RETIRE_CNT_EN adds a wrapping count of register-file writes.
module wb_stage
    import arm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int ALLOW_PC_WB = 0,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 freeze,
    input  logic                 flush,
    input  logic                 mem_valid,
    input  logic                 wb_en_in,
    input  logic                 mem_r_en_in,
    input  logic [REG_IDX_W-1:0] dest_in,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic                 mem_rdy,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic [DATA_W-1:0]    wb_value,
    output logic [REG_IDX_W-1:0] wb_dest,
    output logic                 wb_write_enable,
    output logic                 stall_req,
    output logic                 mem_err,
    output logic [CNT_W-1:0]     retired_count
);

    localparam int TO_W = $clog2(MEM_TIMEOUT + 1);

    wb_state_t            r_state;
    logic [TO_W-1:0]      r_cnt;
    logic                 r_mem_err;
    logic                 r_pend_wb_en;
    logic [REG_IDX_W-1:0] r_pend_dest;

    wb_state_t            w_next_state;
    logic [TO_W-1:0]      w_cnt_next;
    logic                 w_err_set;
    logic                 w_pend_load;
    logic                 w_pr_valid;
    logic                 w_pr_wb_en;
    logic [REG_IDX_W-1:0] w_pr_dest;
    logic [DATA_W-1:0]    w_pr_value;
    logic                 w_is_wait;
    logic                 w_accept;

    logic                 w_valid;
    logic                 w_wb_en;

    assign w_is_wait = (r_state == WAIT_MEM);
    assign w_accept  = mem_valid && !flush && !freeze;

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_err_set    = 1'b0;
        w_pend_load  = 1'b0;
        w_pr_valid   = 1'b0;
        w_pr_wb_en   = wb_en_in;
        w_pr_dest    = dest_in;
        w_pr_value   = alu_result;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (mem_r_en_in && !mem_rdy) begin
                        w_pend_load  = 1'b1;
                        w_next_state = WAIT_MEM;
                        w_cnt_next   = '0;
                    end else begin
                        w_pr_valid = 1'b1;
                        w_pr_value = mem_r_en_in ? mem_rdata : alu_result;
                    end
                end
            end
            WAIT_MEM: begin
                w_pr_wb_en = r_pend_wb_en;
                w_pr_dest  = r_pend_dest;
                w_pr_value = mem_rdata;
                // flush outranks a same-cycle mem_rdy; freeze is ignored here.
                if (flush) begin
                    w_next_state = IDLE;
                    w_cnt_next   = '0;
                end else if (mem_rdy) begin
                    w_pr_valid   = 1'b1;
                    w_next_state = IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == TO_W'(MEM_TIMEOUT - 1)) begin
                    w_err_set    = 1'b1;
                    w_next_state = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_mem_err    <= 1'b0;
            r_pend_wb_en <= 1'b0;
            r_pend_dest  <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            if (w_err_set) begin
                r_mem_err <= 1'b1;
            end
            if (w_pend_load) begin
                r_pend_wb_en <= wb_en_in;
                r_pend_dest  <= dest_in;
            end
        end
    end

    wb_pipe_reg u_pipe_reg (
        .clk      (clk),
        .rst      (rst),
        .i_freeze (freeze && !w_is_wait),
        .i_flush  (flush),
        .i_valid  (w_pr_valid),
        .i_wb_en  (w_pr_wb_en),
        .i_dest   (w_pr_dest),
        .i_value  (w_pr_value),
        .o_valid  (w_valid),
        .o_wb_en  (w_wb_en),
        .o_dest   (wb_dest),
        .o_value  (wb_value)
    );

    assign wb_write_enable = w_valid && w_wb_en &&
                             ((ALLOW_PC_WB != 0) || (wb_dest != REG_PC));
    assign stall_req       = w_is_wait && !mem_rdy;
    assign mem_err         = r_mem_err;

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] r_retired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
        end else if (wb_write_enable) begin
            r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign retired_count = r_retired;
`else
    assign retired_count = '0;
`endif

endmodule
